mat_point_xform: RTL and testbench
==================================

# mat_point_xform

Sequential 2x2 matrix-times-point transform stage that consumes the packed 2x2 matrix produced by the matrix-multiply block and applies it to a stream of 2D sprite/vertex coordinates for the graphics path. It latches one packed matrix, accepts points over a valid/ready handshake, and computes both output coordinates with a single shared multiplier over four cycles. Output points go to the downstream rasteriser over a valid/ready handshake.

## Interface
Parameters:
- W, 8, element and coordinate width; packed matrix is 4*W bits.

Ports:
- clk  in  1  rising-edge system clock; the block has one clock.
- rst_n  in  1  reset, asynchronous, active-low.
- mat_i  in  4*W  packed matrix {m00,m01,m10,m11}, m00 in MSBs, row-major.
- mat_load  in  1  load strobe for mat_i.
- mat_ready  out  1  high when mat_load is honoured (IDLE only).
- pt_valid  in  1  input point valid.
- pt_ready  out  1  input point accepted on clk edge when pt_valid and pt_ready are both high.
- pt_x, pt_y  in  W each  input coordinates.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts result.
- out_x, out_y  out  W each  transformed coordinates.
- busy  out  1  high in any state other than IDLE.

## Operation
- Arithmetic: unsigned, modulo 2^W, matching the matrix-multiply block. out_x = (m00*x + m01*y) mod 2^W; out_y = (m10*x + m11*y) mod 2^W. Products and accumulator are truncated to W bits, with no saturation.
- Matrix register: resets to identity {1,0,0,1}.
  - mat_load is latched only when mat_ready=1. It is ignored in all other states, and the matrix stays stable for the point in flight.
- Simultaneous mat_load and point accept in IDLE: both are taken on the same edge, and the accepted point uses the newly loaded matrix.
- FSM states IDLE, M0, M1, M2, M3, DONE:
  - IDLE: pt_ready=1, mat_ready=1. On accept, latch x and y and go to M0.
  - M0: acc_x = m00*x. Go to M1.
  - M1: out_x = acc_x + m01*y. Go to M2.
  - M2: acc_y = m10*x. Go to M3.
  - M3: out_y = acc_y + m11*y. Go to DONE.
  - DONE: out_valid=1. When out_ready=1, go to IDLE. Otherwise hold with out_x and out_y stable.
- pt_ready and mat_ready are 0 in every state except IDLE.
- Reset mid-operation: returns to IDLE immediately. The in-flight point is discarded and the matrix returns to identity.

## Timing
- Reset values: out_valid=0, out_x=0, out_y=0, pt_ready=1, mat_ready=1, busy=0, state IDLE.
- Latency: a point accepted at edge e0 gives out_valid=1 after edge e4 (4 cycles).
- Throughput: with out_ready held high, the maximum rate is one point per 6 cycles. Accept edges are e0, e6, e12, and so on.
- pt_ready is a pure function of state, with no combinational path from out_ready.
- out_x and out_y are registered. They may change during M1 and M3, but consumers sample them only while out_valid=1.
- Backpressure: while out_valid=1 and out_ready=0, out_valid, out_x and out_y hold with no drop. An input point presented during this time is not accepted.

## Structure
- Shared package mat_pkg:
  - State enum.
  - Default W.
  - Identity-matrix constant MAT_IDENTITY.
  - A function that unpacks 4*W into elements, using the same {m00,m01,m10,m11} ordering as the matrix-multiply block.
- One natural sub-module, mat_mac: a W-bit multiply-accumulate computing (acc_en ? acc : 0) + a*b mod 2^W. It is instantiated once and operand-muxed by the FSM.

## Test plan
- After reset, with the identity matrix, input (7,200) -> out (7,200) at the 4th edge after accept; out_valid stays 0 before that.
- Load {2,3,4,5} and input (10,20) -> out_x=80, out_y=140. Load {255,255,255,255} and input (255,255) -> out (2,2), which checks the mod-256 wrap.
- Hold out_ready=0 for 10 cycles in DONE -> outputs stay stable and pt_ready stays 0. Release out_ready -> one transfer, then IDLE on the next edge.
- Pulse mat_load={0,1,1,0} while in M2 -> it is ignored and the current result uses the old matrix. The same pulse in IDLE together with a point (3,9) -> out (9,3).
- Assert rst_n low during M1 -> out_valid=0 and outputs 0 asynchronously. A subsequent point (5,6) -> (5,6) via the identity matrix.
- Back-to-back stream of 4 points with constant valid and ready -> accepts at edges 0, 6, 12, 18, with results in order.

Source files
------------

// File: rtl/mat_pkg.sv
// Shared types and helpers for the 2x2 matrix transform path: state encoding,
// default width, identity constant and packed-matrix element unpack.
package mat_pkg;

  localparam int MAT_W     = 8;
  localparam int MAT_MAX_W = 16;

  localparam logic [4*MAT_W-1:0] MAT_IDENTITY =
    {MAT_W'(1), MAT_W'(0), MAT_W'(0), MAT_W'(1)};

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_M0,
    ST_M1,
    ST_M2,
    ST_M3,
    ST_DONE
  } mat_state_e;

  localparam int unsigned IDX_00 = 0;
  localparam int unsigned IDX_01 = 1;
  localparam int unsigned IDX_10 = 2;
  localparam int unsigned IDX_11 = 3;

  // Element idx of a packed {m00,m01,m10,m11} matrix of w-bit elements, m00 in MSBs.
  function automatic logic [MAT_MAX_W-1:0] mat_elem(
    input logic [4*MAT_MAX_W-1:0] m,
    input int unsigned            w,
    input int unsigned            idx
  );
    logic [4*MAT_MAX_W-1:0] s;
    s = m >> (w * (3 - idx));
    return s[MAT_MAX_W-1:0] & ((MAT_MAX_W'(1) << w) - MAT_MAX_W'(1));
  endfunction

endpackage

// File: rtl/mat_mac.sv
// W-bit multiply-accumulate, res = (acc_en ? acc : 0) + a*b mod 2^W.
// Combinational, no handshake; the caller registers the result.
module mat_mac #(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [W-1:0] acc,
  input  logic         acc_en,
  output logic [W-1:0] res
);

  assign res = (acc_en ? acc : '0) + a * b;

endmodule

// File: rtl/mat_point_xform.sv
// 2x2 matrix times 2D point over one shared MAC: accept, 4 cycles compute, result held in DONE.
// Output holds under out_ready=0; pt_ready/mat_ready only in IDLE so stalls block new input.
module mat_point_xform
  import mat_pkg::*;
#(
  parameter int W = MAT_W
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [4*W-1:0] mat_i,
  input  logic           mat_load,
  output logic           mat_ready,
  input  logic           pt_valid,
  output logic           pt_ready,
  input  logic [W-1:0]   pt_x,
  input  logic [W-1:0]   pt_y,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [W-1:0]   out_x,
  output logic [W-1:0]   out_y,
  output logic           busy
);

  localparam logic [4*W-1:0] MAT_RST =
    (W == MAT_W) ? (4*W)'(MAT_IDENTITY) : {W'(1), W'(0), W'(0), W'(1)};

  mat_state_e     state_q, state_d;
  logic [4*W-1:0] mat_q;
  logic [W-1:0]   x_q, y_q, acc_q, out_x_q, out_y_q;

  logic [W-1:0]   m00, m01, m10, m11;
  logic [W-1:0]   mac_a, mac_b, mac_res;
  logic           mac_acc_en, acc_we, ox_we, oy_we;

  assign m00 = W'(mat_elem((4*MAT_MAX_W)'(mat_q), W, IDX_00));
  assign m01 = W'(mat_elem((4*MAT_MAX_W)'(mat_q), W, IDX_01));
  assign m10 = W'(mat_elem((4*MAT_MAX_W)'(mat_q), W, IDX_10));
  assign m11 = W'(mat_elem((4*MAT_MAX_W)'(mat_q), W, IDX_11));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (pt_valid) state_d = ST_M0;
      ST_M0:   state_d = ST_M1;
      ST_M1:   state_d = ST_M2;
      ST_M2:   state_d = ST_M3;
      ST_M3:   state_d = ST_DONE;
      ST_DONE: if (out_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    pt_ready   = (state_q == ST_IDLE);
    mat_ready  = (state_q == ST_IDLE);
    busy       = (state_q != ST_IDLE);
    out_valid  = (state_q == ST_DONE);
    mac_a      = m00;
    mac_b      = x_q;
    mac_acc_en = 1'b0;
    acc_we     = 1'b0;
    ox_we      = 1'b0;
    oy_we      = 1'b0;
    case (state_q)
      ST_M0: begin
        mac_a  = m00;
        mac_b  = x_q;
        acc_we = 1'b1;
      end
      ST_M1: begin
        mac_a      = m01;
        mac_b      = y_q;
        mac_acc_en = 1'b1;
        ox_we      = 1'b1;
      end
      ST_M2: begin
        mac_a  = m10;
        mac_b  = x_q;
        acc_we = 1'b1;
      end
      ST_M3: begin
        mac_a      = m11;
        mac_b      = y_q;
        mac_acc_en = 1'b1;
        oy_we      = 1'b1;
      end
      default: ;
    endcase
  end

  mat_mac #(.W(W)) u_mac (
    .a      (mac_a),
    .b      (mac_b),
    .acc    (acc_q),
    .acc_en (mac_acc_en),
    .res    (mac_res)
  );

  // A load and a point accepted on the same IDLE edge: M0 reads the new mat_q.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mat_q   <= MAT_RST;
      x_q     <= '0;
      y_q     <= '0;
      acc_q   <= '0;
      out_x_q <= '0;
      out_y_q <= '0;
    end else begin
      if (mat_load && mat_ready) mat_q <= mat_i;
      if (pt_valid && pt_ready) begin
        x_q <= pt_x;
        y_q <= pt_y;
      end
      if (acc_we) acc_q   <= mac_res;
      if (ox_we)  out_x_q <= mac_res;
      if (oy_we)  out_y_q <= mac_res;
    end
  end

  assign out_x = out_x_q;
  assign out_y = out_y_q;

endmodule

// File: tb/tb_mat_point_xform.sv
// Bench for mat_point_xform: directed scenarios plus randomized matrices/points
// checked against a plain-arithmetic model of the matrix-times-point rule.
module tb_mat_point_xform;

  localparam int W   = 8;
  localparam int MOD = 1 << W;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [4*W-1:0] mat_i;
  logic           mat_load;
  logic           mat_ready;
  logic           pt_valid;
  logic           pt_ready;
  logic [W-1:0]   pt_x, pt_y;
  logic           out_valid;
  logic           out_ready;
  logic [W-1:0]   out_x, out_y;
  logic           busy;

  int tests_run    = 0;
  int tests_failed = 0;
  int ref_m[4]     = '{1, 0, 0, 1};
  int cyc_cnt      = 0;
  int acc_cyc[$];
  logic [W-1:0] obs_x[$];
  logic [W-1:0] obs_y[$];

  always #5 clk = ~clk;

  mat_point_xform #(.W(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .mat_i     (mat_i),
    .mat_load  (mat_load),
    .mat_ready (mat_ready),
    .pt_valid  (pt_valid),
    .pt_ready  (pt_ready),
    .pt_x      (pt_x),
    .pt_y      (pt_y),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_x     (out_x),
    .out_y     (out_y),
    .busy      (busy)
  );

  always @(posedge clk) begin
    cyc_cnt++;
    if (rst_n && pt_valid && pt_ready) acc_cyc.push_back(cyc_cnt);
    if (rst_n && out_valid && out_ready) begin
      obs_x.push_back(out_x);
      obs_y.push_back(out_y);
    end
  end

  function automatic int ref_ox(input int x, input int y);
    return (ref_m[0] * x + ref_m[1] * y) % MOD;
  endfunction

  function automatic int ref_oy(input int x, input int y);
    return (ref_m[2] * x + ref_m[3] * y) % MOD;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_mat(input int a, input int b, input int c, input int d);
    mat_i    = {a[W-1:0], b[W-1:0], c[W-1:0], d[W-1:0]};
    mat_load = 1'b1;
    tick();
    mat_load = 1'b0;
    ref_m    = '{a, b, c, d};
  endtask

  // Presents a point, waits (bounded) for IDLE, and returns just after the accept edge.
  task automatic send_point(input int x, input int y);
    int n;
    pt_valid = 1'b1;
    pt_x     = x[W-1:0];
    pt_y     = y[W-1:0];
    n = 0;
    while (!pt_ready && n < 50) begin
      tick();
      n++;
    end
    tick();
    pt_valid = 1'b0;
  endtask

  task automatic wait_out(output int cyc);
    cyc = 0;
    while (!out_valid && cyc < 40) begin
      tick();
      cyc++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) tick();
    tests_run += 6;
    if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    if (out_x !== 8'd0) begin tests_failed++; $display("FAIL reset_out_x got %0d want 0", out_x); end
    if (out_y !== 8'd0) begin tests_failed++; $display("FAIL reset_out_y got %0d want 0", out_y); end
    if (pt_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_pt_ready got %b want 1", pt_ready); end
    if (mat_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_mat_ready got %b want 1", mat_ready); end
    if (busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy got %b want 0", busy); end
    rst_n = 1'b1;
    ref_m = '{1, 0, 0, 1};
    tick();
  endtask

  task automatic test_identity();
    int cyc;
    send_point(7, 200);
    wait_out(cyc);
    tests_run += 3;
    if (cyc !== 4) begin tests_failed++; $display("FAIL ident_latency got %0d want 4", cyc); end
    if (out_x !== ref_ox(7, 200)) begin tests_failed++; $display("FAIL ident_x got %0d want %0d", out_x, ref_ox(7, 200)); end
    if (out_y !== ref_oy(7, 200)) begin tests_failed++; $display("FAIL ident_y got %0d want %0d", out_y, ref_oy(7, 200)); end
    tick();
  endtask

  task automatic test_load_and_wrap();
    int cyc;
    load_mat(2, 3, 4, 5);
    send_point(10, 20);
    wait_out(cyc);
    tests_run += 3;
    if (cyc !== 4) begin tests_failed++; $display("FAIL load_latency got %0d want 4", cyc); end
    if (out_x !== ref_ox(10, 20)) begin tests_failed++; $display("FAIL load_x got %0d want %0d", out_x, ref_ox(10, 20)); end
    if (out_y !== ref_oy(10, 20)) begin tests_failed++; $display("FAIL load_y got %0d want %0d", out_y, ref_oy(10, 20)); end
    tick();
    load_mat(255, 255, 255, 255);
    send_point(255, 255);
    wait_out(cyc);
    tests_run += 2;
    if (out_x !== ref_ox(255, 255)) begin tests_failed++; $display("FAIL wrap_x got %0d want %0d", out_x, ref_ox(255, 255)); end
    if (out_y !== ref_oy(255, 255)) begin tests_failed++; $display("FAIL wrap_y got %0d want %0d", out_y, ref_oy(255, 255)); end
    tick();
  endtask

  task automatic test_backpressure();
    int cyc, x, y, bad;
    x = $urandom_range(0, 255);
    y = $urandom_range(0, 255);
    out_ready = 1'b0;
    send_point(x, y);
    wait_out(cyc);
    pt_valid = 1'b1;
    pt_x     = 8'd1;
    pt_y     = 8'd1;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      tests_run++;
      if (out_valid !== 1'b1 || out_x !== ref_ox(x, y) || out_y !== ref_oy(x, y) || pt_ready !== 1'b0) begin
        tests_failed++;
        $display("FAIL bp_hold cycle %0d got v=%b x=%0d y=%0d rdy=%b want v=1 x=%0d y=%0d rdy=0",
                 i, out_valid, out_x, out_y, pt_ready, ref_ox(x, y), ref_oy(x, y));
      end
    end
    pt_valid  = 1'b0;
    out_ready = 1'b1;
    obs_x.delete();
    tick();
    tests_run += 3;
    if (obs_x.size() !== 1) begin tests_failed++; $display("FAIL bp_transfers got %0d want 1", obs_x.size()); end
    if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL bp_release_valid got %b want 0", out_valid); end
    if (busy !== 1'b0) begin tests_failed++; $display("FAIL bp_release_idle busy got %b want 0", busy); end
  endtask

  task automatic test_mat_load_gating();
    int cyc, x, y;
    x = $urandom_range(0, 255);
    y = $urandom_range(0, 255);
    send_point(x, y);
    tick();
    tick();
    mat_i    = {8'd0, 8'd1, 8'd1, 8'd0};
    mat_load = 1'b1;
    tests_run++;
    if (mat_ready !== 1'b0) begin tests_failed++; $display("FAIL busy_mat_ready got %b want 0", mat_ready); end
    tick();
    mat_load = 1'b0;
    wait_out(cyc);
    tests_run += 2;
    if (out_x !== ref_ox(x, y)) begin tests_failed++; $display("FAIL busy_load_x got %0d want %0d", out_x, ref_ox(x, y)); end
    if (out_y !== ref_oy(x, y)) begin tests_failed++; $display("FAIL busy_load_y got %0d want %0d", out_y, ref_oy(x, y)); end
    tick();
    mat_i    = {8'd0, 8'd1, 8'd1, 8'd0};
    mat_load = 1'b1;
    send_point(3, 9);
    mat_load = 1'b0;
    ref_m    = '{0, 1, 1, 0};
    wait_out(cyc);
    tests_run += 3;
    if (cyc !== 4) begin tests_failed++; $display("FAIL simul_latency got %0d want 4", cyc); end
    if (out_x !== ref_ox(3, 9)) begin tests_failed++; $display("FAIL simul_x got %0d want %0d", out_x, ref_ox(3, 9)); end
    if (out_y !== ref_oy(3, 9)) begin tests_failed++; $display("FAIL simul_y got %0d want %0d", out_y, ref_oy(3, 9)); end
    tick();
  endtask

  task automatic test_reset_mid();
    int cyc;
    send_point(11, 22);
    tick();
    rst_n = 1'b0;
    #1;
    tests_run += 5;
    if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL rmid_valid got %b want 0", out_valid); end
    if (out_x !== 8'd0) begin tests_failed++; $display("FAIL rmid_x got %0d want 0", out_x); end
    if (out_y !== 8'd0) begin tests_failed++; $display("FAIL rmid_y got %0d want 0", out_y); end
    if (busy !== 1'b0) begin tests_failed++; $display("FAIL rmid_busy got %b want 0", busy); end
    if (pt_ready !== 1'b1) begin tests_failed++; $display("FAIL rmid_pt_ready got %b want 1", pt_ready); end
    tick();
    rst_n = 1'b1;
    ref_m = '{1, 0, 0, 1};
    send_point(5, 6);
    wait_out(cyc);
    tests_run += 3;
    if (cyc !== 4) begin tests_failed++; $display("FAIL rmid_after_latency got %0d want 4", cyc); end
    if (out_x !== ref_ox(5, 6)) begin tests_failed++; $display("FAIL rmid_after_x got %0d want %0d", out_x, ref_ox(5, 6)); end
    if (out_y !== ref_oy(5, 6)) begin tests_failed++; $display("FAIL rmid_after_y got %0d want %0d", out_y, ref_oy(5, 6)); end
    tick();
  endtask

  task automatic test_back_to_back();
    int px[4], py[4], ex[$], ey[$];
    int idx, n;
    load_mat($urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255));
    for (int i = 0; i < 4; i++) begin
      px[i] = $urandom_range(0, 255);
      py[i] = $urandom_range(0, 255);
      ex.push_back(ref_ox(px[i], py[i]));
      ey.push_back(ref_oy(px[i], py[i]));
    end
    acc_cyc.delete();
    obs_x.delete();
    obs_y.delete();
    out_ready = 1'b1;
    idx = 0;
    pt_valid = 1'b1;
    pt_x = px[0][W-1:0];
    pt_y = py[0][W-1:0];
    n = 0;
    while (idx < 4 && n < 100) begin
      tick();
      n++;
      if (acc_cyc.size() > idx) begin
        idx++;
        if (idx < 4) begin
          pt_x = px[idx][W-1:0];
          pt_y = py[idx][W-1:0];
        end else begin
          pt_valid = 1'b0;
        end
      end
    end
    pt_valid = 1'b0;
    n = 0;
    while (obs_x.size() < 4 && n < 100) begin
      tick();
      n++;
    end
    tests_run += 2;
    if (acc_cyc.size() !== 4) begin tests_failed++; $display("FAIL b2b_accepts got %0d want 4", acc_cyc.size()); end
    if (obs_x.size() !== 4) begin tests_failed++; $display("FAIL b2b_results got %0d want 4", obs_x.size()); end
    for (int i = 1; i < acc_cyc.size(); i++) begin
      tests_run++;
      if (acc_cyc[i] - acc_cyc[i-1] !== 6) begin
        tests_failed++;
        $display("FAIL b2b_spacing %0d got %0d want 6", i, acc_cyc[i] - acc_cyc[i-1]);
      end
    end
    for (int i = 0; i < obs_x.size() && i < 4; i++) begin
      tests_run++;
      if (obs_x[i] !== ex[i][W-1:0] || obs_y[i] !== ey[i][W-1:0]) begin
        tests_failed++;
        $display("FAIL b2b_result %0d got (%0d,%0d) want (%0d,%0d)", i, obs_x[i], obs_y[i], ex[i], ey[i]);
      end
    end
  endtask

  task automatic test_random();
    int cyc, x, y, stall;
    for (int t = 0; t < 8; t++) begin
      load_mat($urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255));
      x = $urandom_range(0, 255);
      y = $urandom_range(0, 255);
      stall = $urandom_range(0, 3);
      out_ready = (stall == 0);
      send_point(x, y);
      wait_out(cyc);
      repeat (stall) tick();
      tests_run += 3;
      if (cyc !== 4) begin tests_failed++; $display("FAIL rand%0d_latency got %0d want 4", t, cyc); end
      if (out_x !== ref_ox(x, y)) begin tests_failed++; $display("FAIL rand%0d_x got %0d want %0d", t, out_x, ref_ox(x, y)); end
      if (out_y !== ref_oy(x, y)) begin tests_failed++; $display("FAIL rand%0d_y got %0d want %0d", t, out_y, ref_oy(x, y)); end
      out_ready = 1'b1;
      tick();
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    mat_i     = '0;
    mat_load  = 1'b0;
    pt_valid  = 1'b0;
    pt_x      = '0;
    pt_y      = '0;
    out_ready = 1'b1;
    test_reset();
    test_identity();
    test_load_and_wrap();
    test_backpressure();
    test_mat_load_gating();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
